// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and constants for the ring-oscillator PUF controller
package puf_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} puf_state_t;
  localparam int SETTLE_CYC = 4;
  localparam int CHAL_W = 5;
endpackage

// File: rtl/puf_challenge_ctrl_if.sv
// puf_challenge_ctrl_if: run control and response handshake between consumer and PUF controller
interface puf_challenge_ctrl_if #(parameter int NRESP = 8);
  import puf_pkg::*;
  logic start;
  logic [CHAL_W-1:0] seed;
  logic busy;
  logic [NRESP-1:0] resp;
  logic resp_valid;
  logic resp_ready;
  modport master(output start, seed, resp_ready, input busy, resp, resp_valid);
  modport slave(input start, seed, resp_ready, output busy, resp, resp_valid);
endinterface

// File: rtl/puf_edge_counter.sv
// puf_edge_counter: 2-FF synchronizer, rising-edge detect and saturating edge counter
module puf_edge_counter #(parameter int CNT_W = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ro,
  output logic [CNT_W-1:0] cnt
);
  logic s1, s2, d;
  // clr flushes the pipeline too, so a stale level cannot fake an edge in the next window
  always_ff @(posedge clk)
    if (rst_n || clr) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      d   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= ro;
      s2 <= s1;
      d  <= s2;
      if (en && s2 && !d && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/puf_challenge_ctrl.sv
// puf_challenge_ctrl: sequences challenges, counts both oscillator banks and assembles the response word
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter int WINDOW = 255,
  parameter int CNT_W  = 8,
  parameter int NRESP  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic [CHAL_W-1:0] chal,
  output logic              ro_en,
  puf_challenge_ctrl_if.slave bus
);
  localparam int PH_W = $clog2(WINDOW);
  localparam int IX_W = NRESP > 1 ? $clog2(NRESP) : 1;
  puf_state_t state, nxt;
  logic [PH_W-1:0] ph;
  logic [IX_W-1:0] idx;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clr(state == SETTLE), .en(state == COUNT), .ro(ro_a), .cnt(cnt_a)
  );
  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clr(state == SETTLE), .en(state == COUNT), .ro(ro_b), .cnt(cnt_b)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? SETTLE : IDLE;
      SETTLE:  nxt = ph == PH_W'(SETTLE_CYC - 1) ? COUNT : SETTLE;
      COUNT:   nxt = ph == PH_W'(WINDOW - 1) ? COMPARE : COUNT;
      COMPARE: nxt = idx == IX_W'(NRESP - 1) ? DONE : SETTLE;
      DONE:    nxt = bus.resp_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // flag outputs are taken from the next state so they are registered yet aligned with it
  always_ff @(posedge clk)
    if (rst_n) begin
      state          <= IDLE;
      ph             <= '0;
      idx            <= '0;
      chal           <= '0;
      ro_en          <= 1'b0;
      bus.busy       <= 1'b0;
      bus.resp       <= '0;
      bus.resp_valid <= 1'b0;
    end else begin
      state          <= nxt;
      ph             <= nxt != state ? '0 : ph + 1'b1;
      ro_en          <= nxt inside {SETTLE, COUNT};
      bus.busy       <= nxt != IDLE;
      bus.resp_valid <= nxt == DONE;
      if (state == IDLE && bus.start) begin
        chal     <= bus.seed;
        idx      <= '0;
        bus.resp <= '0;
      end
      if (state == COMPARE) begin
        bus.resp[idx] <= cnt_a > cnt_b;
        if (nxt == SETTLE) begin
          idx  <= idx + 1'b1;
          chal <= chal + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb_puf_challenge_ctrl: directed checks of challenge sequencing, response, handshake and reset
module tb_puf_challenge_ctrl;
  import puf_pkg::*;
  localparam int W = 16, N = 8, W2 = 57, N2 = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic ro_a, ro_b, ro_a2, ro_b2, ro_en, ro_en2;
  logic [CHAL_W-1:0] chal, chal2;
  int errors = 0, checks = 0, mode = 0, cyc = 0, lat = 0;
  puf_challenge_ctrl_if #(.NRESP(N)) bus();
  puf_challenge_ctrl_if #(.NRESP(N2)) bus2();
  puf_challenge_ctrl #(.WINDOW(W), .CNT_W(8), .NRESP(N)) dut (
    .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b), .chal(chal), .ro_en(ro_en), .bus(bus)
  );
  puf_challenge_ctrl #(.WINDOW(W2), .CNT_W(3), .NRESP(N2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ro_a(ro_a2), .ro_b(ro_b2), .chal(chal2), .ro_en(ro_en2), .bus(bus2)
  );
  always @(negedge clk) cyc <= cyc + 1;
  assign ro_a  = mode != 0 && (cyc / 2) % 2 == 1;
  assign ro_b  = mode == 2 && (cyc / 2) % 2 == 1;
  assign ro_a2 = (cyc / 2) % 2 == 1;
  assign ro_b2 = (cyc / 3) % 2 == 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_reset();
    chk("rst_chal", 32'(chal), 0);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_resp", 32'(bus.resp), 0);
    chk("rst_valid", 32'(bus.resp_valid), 0);
  endtask
  task automatic run(input logic [CHAL_W-1:0] seed, input logic [N-1:0] exp, input bit poke);
    bus.seed  = seed;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.seed  = '0;
    chk("busy_after_start", 32'(bus.busy), 1);
    for (int k = 0; k < N; k++) begin
      chk("chal_settle", 32'(chal), 32'(5'(seed + 5'(k))));
      chk("ro_en_settle", 32'(ro_en), 1);
      if (poke && k == 0) begin
        step(6);
        bus.seed  = 5'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(13);
      end else step(20);
      chk("chal_compare", 32'(chal), 32'(5'(seed + 5'(k))));
      chk("ro_en_compare", 32'(ro_en), 0);
      chk("valid_early", 32'(bus.resp_valid), 0);
      step();
    end
    chk("valid_rise", 32'(bus.resp_valid), 1);
    chk("resp", 32'(bus.resp), 32'(exp));
    chk("busy_done", 32'(bus.busy), 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.seed = '0;
    bus.resp_ready = 1'b0;
    bus2.start = 1'b0;
    bus2.seed = '0;
    bus2.resp_ready = 1'b0;
    mode = 1;
    bus.start = 1'b1;
    step(2);
    rst_n = 1'b0;
    bus.start = 1'b0;
    chk_reset();
    step();
    chk("start_in_reset_dropped", 32'(bus.busy), 0);
    run(5'h00, 8'hFF, 1'b0);
    step(20);
    chk("bp_valid", 32'(bus.resp_valid), 1);
    chk("bp_resp", 32'(bus.resp), 32'hFF);
    chk("bp_busy", 32'(bus.busy), 1);
    bus.resp_ready = 1'b1;
    step();
    chk("xfer_valid", 32'(bus.resp_valid), 0);
    chk("xfer_busy", 32'(bus.busy), 0);
    chk("xfer_resp_hold", 32'(bus.resp), 32'h FF);
    mode = 2;
    run(5'h1E, 8'h00, 1'b0);
    step();
    chk("tie_idle", 32'(bus.busy), 0);
    mode = 1;
    run(5'h03, 8'hFF, 1'b1);
    step();
    chk("poke_idle", 32'(bus.busy), 0);
    step(3);
    chk("poke_not_queued", 32'(bus.busy), 0);
    bus.seed = 5'h10;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(3 * (W + 5) + 8);
    chk("partial_resp", 32'(bus.resp), 32'h07);
    chk("partial_chal", 32'(chal), 32'h13);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk_reset();
    run(5'h10, 8'hFF, 1'b0);
    step();
    chk("rerun_idle", 32'(bus.busy), 0);
    bus2.resp_ready = 1'b1;
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    for (lat = 0; lat < 300 && !bus2.resp_valid; lat++) step();
    chk("sat_latency", 32'(lat), 32'(N2 * (W2 + 5)));
    chk("sat_resp", 32'(bus2.resp), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
